id_stage_pipelined: RTL and testbench

//  Parametrised decode stage: field split, register file, immediate gen and control,

---
 rtl/id_stage_pipelined.sv | 131 +++++++++++++
 tb/tb_id_stage_pipelined.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined: decode stage with regfile, imm/control gen, load-use stall and ID/EX register
module id_stage_pipelined #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic            ex_branch,
    output logic            ex_memread,
    output logic            ex_memtoreg,
    output logic            ex_memwrite,
    output logic            ex_alusrc,
    output logic            ex_regwrite,
    output logic [1:0]      ex_aluop,
    output logic            hazard_stall
);
    localparam int AW = $clog2(NREGS);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] rf [NREGS];
    logic [XLEN-1:0] rs1_data, rs2_data, imm;
    logic [31:0]     imm32;
    logic [7:0]      ctrl;
    logic            wr_en, uses_rs2, advance;

    assign opcode = if_inst[6:0];
    assign rd     = if_inst[11:7];
    assign rs1    = if_inst[19:15];
    assign rs2    = if_inst[24:20];

    // Indices beyond the implemented file (RV32E-style) read as zero and are never written
    assign wr_en    = wb_en && wb_rd != 5'd0 && (wb_rd >> AW) == 5'd0;
    assign rs1_data = (rs1 == 5'd0 || (rs1 >> AW) != 5'd0) ? '0 :
                      (BYPASS != 0 && wb_en && wb_rd == rs1) ? wb_data : rf[rs1[AW-1:0]];
    assign rs2_data = (rs2 == 5'd0 || (rs2 >> AW) != 5'd0) ? '0 :
                      (BYPASS != 0 && wb_en && wb_rd == rs2) ? wb_data : rf[rs2[AW-1:0]];

    // Immediate is assembled as 32 bits then sign-extended so XLEN=32 needs no special case
    assign imm32 = (opcode == OP_LD || opcode == OP_I || opcode == OP_JALR) ? {{20{if_inst[31]}}, if_inst[31:20]} :
                   (opcode == OP_ST) ? {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]} :
                   (opcode == OP_BR) ? {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0} :
                   (opcode == OP_LUI || opcode == OP_AUIPC) ? {if_inst[31:12], 12'b0} :
                   (opcode == OP_JAL) ? {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0} :
                   32'd0;
    assign imm = XLEN'($signed(imm32));

    // ctrl = {branch, memread, memtoreg, memwrite, alusrc, regwrite, aluop}
    assign ctrl = (opcode == OP_R)  ? 8'b00000110 :
                  (opcode == OP_I)  ? 8'b00001111 :
                  (opcode == OP_LD) ? 8'b01101100 :
                  (opcode == OP_ST) ? 8'b00011000 :
                  (opcode == OP_BR) ? 8'b10000001 : 8'b00000000;

    // Only R, store and branch actually consume rs2; I-type rs2 field is immediate bits
    assign uses_rs2     = opcode == OP_R || opcode == OP_ST || opcode == OP_BR;
    assign hazard_stall = if_valid && ex_valid && ex_memread && ex_rd != 5'd0 &&
                          (ex_rd == rs1 || (ex_rd == rs2 && uses_rs2));
    assign advance      = !ex_valid || ex_ready;
    assign id_ready     = advance && !hazard_stall;

    // Register file write from write-back; x0 stays zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (wr_en) begin
            rf[wb_rd[AW-1:0]] <= wb_data;
        end
    end

    // ID/EX register: flush, then load-use bubble, then advance, else hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_funct7   <= '0;
            {ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite, ex_aluop} <= '0;
        end else if (flush || (advance && hazard_stall)) begin
            ex_valid <= 1'b0;
            {ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite, ex_aluop} <= '0;
        end else if (advance) begin
            ex_valid    <= if_valid;
            ex_pc       <= if_pc;
            ex_rs1_data <= rs1_data;
            ex_rs2_data <= rs2_data;
            ex_imm      <= imm;
            ex_rs1      <= rs1;
            ex_rs2      <= rs2;
            ex_rd       <= rd;
            ex_funct3   <= if_inst[14:12];
            ex_funct7   <= if_inst[31:25];
            {ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite, ex_aluop} <= if_valid ? ctrl : 8'd0;
        end
    end
endmodule

// File: tb/tb_id_stage_pipelined.sv
// tb_id_stage_pipelined: directed vector bench for the decode stage
module tb_id_stage_pipelined;
    logic        clk = 0, reset = 0, if_valid = 0, flush = 0, wb_en = 0, ex_ready = 1;
    logic [31:0] if_inst = 0;
    logic [63:0] if_pc = 0, wb_data = 0;
    logic [4:0]  wb_rd = 0;

    logic        id_ready, ex_valid, hazard_stall;
    logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite;
    logic [1:0]  ex_aluop;
    logic [7:0]  ex_ctrl;

    logic        b_id_ready, b_ex_valid, b_hazard_stall;
    logic [63:0] b_ex_pc, b_ex_rs1_data, b_ex_rs2_data, b_ex_imm;
    logic [4:0]  b_ex_rs1, b_ex_rs2, b_ex_rd;
    logic [2:0]  b_ex_funct3;
    logic [6:0]  b_ex_funct7;
    logic        b_ex_branch, b_ex_memread, b_ex_memtoreg, b_ex_memwrite, b_ex_alusrc, b_ex_regwrite;
    logic [1:0]  b_ex_aluop;

    int n_checks = 0, n_fail = 0;

    assign ex_ctrl = {ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite, ex_aluop};

    id_stage_pipelined #(.XLEN(64), .NREGS(32), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_branch(ex_branch), .ex_memread(ex_memread),
        .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
        .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop), .hazard_stall(hazard_stall)
    );

    id_stage_pipelined #(.XLEN(64), .NREGS(32), .BYPASS(0)) dut_nobyp (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_ready(b_id_ready), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_ready(ex_ready), .ex_valid(b_ex_valid), .ex_pc(b_ex_pc), .ex_rs1_data(b_ex_rs1_data),
        .ex_rs2_data(b_ex_rs2_data), .ex_imm(b_ex_imm), .ex_rs1(b_ex_rs1), .ex_rs2(b_ex_rs2), .ex_rd(b_ex_rd),
        .ex_funct3(b_ex_funct3), .ex_funct7(b_ex_funct7), .ex_branch(b_ex_branch), .ex_memread(b_ex_memread),
        .ex_memtoreg(b_ex_memtoreg), .ex_memwrite(b_ex_memwrite), .ex_alusrc(b_ex_alusrc),
        .ex_regwrite(b_ex_regwrite), .ex_aluop(b_ex_aluop), .hazard_stall(b_hazard_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [7:0]  ctrl;
        logic [4:0]  rd;
        logic [63:0] d1;
        logic [63:0] d2;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [63:0] pc);
        if_valid = 1;
        if_inst  = inst;
        if_pc    = pc;
    endtask

    initial begin
        // x5 = 0xDEAD, all other registers 0 while the table runs
        vecs[0]  = '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 5'd1,  64'h0,    64'h0};
        vecs[1]  = '{32'h0052A423, 64'h8,                8'h18, 5'd8,  64'hDEAD, 64'hDEAD};
        vecs[2]  = '{32'hFE52AE23, 64'hFFFFFFFFFFFFFFFC, 8'h18, 5'd28, 64'hDEAD, 64'hDEAD};
        vecs[3]  = '{32'hFE028CE3, 64'hFFFFFFFFFFFFFFF8, 8'h81, 5'd25, 64'hDEAD, 64'h0};
        vecs[4]  = '{32'h00028863, 64'h10,               8'h81, 5'd16, 64'hDEAD, 64'h0};
        vecs[5]  = '{32'h800003B7, 64'hFFFFFFFF80000000, 8'h00, 5'd7,  64'h0,    64'h0};
        vecs[6]  = '{32'h12345417, 64'h12345000,         8'h00, 5'd8,  64'h0,    64'h0};
        vecs[7]  = '{32'h001000EF, 64'h800,              8'h00, 5'd1,  64'h0,    64'h0};
        vecs[8]  = '{32'hFFFFF0EF, 64'hFFFFFFFFFFFFFFFE, 8'h00, 5'd1,  64'h0,    64'h0};
        vecs[9]  = '{32'hFFF280E7, 64'hFFFFFFFFFFFFFFFF, 8'h00, 5'd1,  64'hDEAD, 64'h0};
        vecs[10] = '{32'hFFFFFFFF, 64'h0,                8'h00, 5'd31, 64'h0,    64'h0};
        vecs[11] = '{32'h400284B3, 64'h0,                8'h06, 5'd9,  64'hDEAD, 64'h0};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(ex_valid), 64'd0);
        chk("rst_pc", ex_pc, 64'd0);
        chk("rst_imm", ex_imm, 64'd0);
        chk("rst_rs1d", ex_rs1_data, 64'd0);
        chk("rst_ctrl", 64'(ex_ctrl), 64'd0);
        chk("rst_rd", 64'(ex_rd), 64'd0);
        reset = 1;
        #1;
        chk("rst_id_ready", 64'(id_ready), 64'd1);

        // add x1,x5,x5 reads zero after reset
        drive(32'h005280B3, 64'h100);
        tick;
        chk("x5_init_valid", 64'(ex_valid), 64'd1);
        chk("x5_init_rs1d", ex_rs1_data, 64'd0);
        chk("add_ctrl", 64'(ex_ctrl), 64'h06);
        chk("add_rd", 64'(ex_rd), 64'd1);

        // write-back bypass into same-cycle read
        drive(32'h005280B3, 64'h104);
        wb_en = 1; wb_rd = 5; wb_data = 64'hDEAD;
        tick;
        wb_en = 0;
        chk("byp_rs1d", ex_rs1_data, 64'hDEAD);
        chk("byp_rs2d", ex_rs2_data, 64'hDEAD);
        chk("nobyp_rs1d", b_ex_rs1_data, 64'h0);
        tick;
        chk("nobyp_written", b_ex_rs1_data, 64'hDEAD);

        // writes to x0 are dropped, also on the bypass path
        drive(32'h000000B3, 64'h108);
        wb_en = 1; wb_rd = 0; wb_data = 64'hFFFF;
        tick;
        wb_en = 0;
        chk("x0_byp", ex_rs1_data, 64'h0);
        tick;
        chk("x0_read", ex_rs1_data, 64'h0);

        // decode table
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].inst, 64'h1000 + 64'(4 * i));
            tick;
            chk($sformatf("v%0d_valid", i), 64'(ex_valid), 64'd1);
            chk($sformatf("v%0d_pc", i), ex_pc, 64'h1000 + 64'(4 * i));
            chk($sformatf("v%0d_imm", i), ex_imm, vecs[i].imm);
            chk($sformatf("v%0d_ctrl", i), 64'(ex_ctrl), 64'(vecs[i].ctrl));
            chk($sformatf("v%0d_rd", i), 64'(ex_rd), 64'(vecs[i].rd));
            chk($sformatf("v%0d_rs1d", i), ex_rs1_data, vecs[i].d1);
            chk($sformatf("v%0d_rs2d", i), ex_rs2_data, vecs[i].d2);
        end
        chk("sub_funct7", 64'(ex_funct7), 64'h20);
        chk("sub_funct3", 64'(ex_funct3), 64'h0);
        chk("sub_rs1", 64'(ex_rs1), 64'd5);
        chk("sub_rs2", 64'(ex_rs2), 64'd0);

        // invalid input passes through as empty slot
        if_valid = 0;
        tick;
        chk("inv_valid", 64'(ex_valid), 64'd0);
        chk("inv_ctrl", 64'(ex_ctrl), 64'd0);

        // load-use on rs1 with write-back to the stalled source
        drive(32'h00013183, 64'h200);
        tick;
        chk("ld_memread", 64'(ex_memread), 64'd1);
        chk("ld_ctrl", 64'(ex_ctrl), 64'h6C);
        drive(32'h00118233, 64'h204);
        #1;
        chk("lu_stall", 64'(hazard_stall), 64'd1);
        chk("lu_id_ready", 64'(id_ready), 64'd0);
        wb_en = 1; wb_rd = 3; wb_data = 64'h77;
        tick;
        wb_en = 0;
        chk("bubble_valid", 64'(ex_valid), 64'd0);
        chk("bubble_ctrl", 64'(ex_ctrl), 64'd0);
        chk("bubble_stall", 64'(hazard_stall), 64'd0);
        chk("bubble_id_ready", 64'(id_ready), 64'd1);
        tick;
        chk("lu_add_valid", 64'(ex_valid), 64'd1);
        chk("lu_add_pc", ex_pc, 64'h204);
        chk("lu_add_rd", 64'(ex_rd), 64'd4);
        chk("lu_add_rs1d", ex_rs1_data, 64'h77);

        // I-type rs2 field is immediate: no hazard
        drive(32'h00013183, 64'h208);
        tick;
        drive(32'h00308313, 64'h20C);
        #1;
        chk("itype_nostall", 64'(hazard_stall), 64'd0);
        tick;
        chk("itype_pc", ex_pc, 64'h20C);

        // load-use on rs2 of R-type
        drive(32'h00013183, 64'h210);
        tick;
        drive(32'h00308233, 64'h214);
        #1;
        chk("rs2_stall", 64'(hazard_stall), 64'd1);
        tick;
        tick;
        chk("rs2_add_pc", ex_pc, 64'h214);
        chk("rs2_add_valid", 64'(ex_valid), 64'd1);

        // backpressure then flush
        drive(32'h400284B3, 64'h300);
        tick;
        ex_ready = 0;
        drive(32'hFFF00093, 64'h304);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d_id_ready", k), 64'(id_ready), 64'd0);
            tick;
            chk($sformatf("bp%0d_pc", k), ex_pc, 64'h300);
            chk($sformatf("bp%0d_valid", k), 64'(ex_valid), 64'd1);
        end
        flush = 1;
        tick;
        flush = 0;
        chk("flush_valid", 64'(ex_valid), 64'd0);
        ex_ready = 1;
        #1;
        chk("flush_id_ready", 64'(id_ready), 64'd1);
        tick;
        chk("after_flush_pc", ex_pc, 64'h304);
        chk("after_flush_imm", ex_imm, 64'hFFFFFFFFFFFFFFFF);

        // async reset during a stall
        drive(32'h00013183, 64'h400);
        tick;
        drive(32'h00118233, 64'h404);
        #1;
        chk("mid_stall", 64'(hazard_stall), 64'd1);
        #2 reset = 0;
        #1;
        chk("arst_valid", 64'(ex_valid), 64'd0);
        chk("arst_memread", 64'(ex_memread), 64'd0);
        chk("arst_pc", ex_pc, 64'd0);
        chk("arst_stall", 64'(hazard_stall), 64'd0);
        reset = 1;
        drive(32'h005280B3, 64'h500);
        tick;
        chk("arst_rf_cleared", ex_rs1_data, 64'd0);
        chk("arst_new_valid", 64'(ex_valid), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
